// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM state encoding, the MEM/WB
// payload layout with its bubble value, and the access wait-counter width.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } memwb_t;

    localparam memwb_t BUBBLE = '{
        alu_res:    32'h0,
        rdata:      32'h0,
        rd:         5'h0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0
    };

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register: every edge it captures either the supplied fields
// or a bubble; asynchronous active-high reset to the bubble value.
module memwb_reg
    import mem_stage_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load_fields,
    input  memwb_t fields,
    output memwb_t q
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the processes are evaluated in.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= BUBBLE;
        end else if (load_fields) begin
            q <= fields;
        end else begin
            q <= BUBBLE;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage merged with MEM/WB: runs loads/stores over a req/ack handshake,
// stalls upstream while busy, aborts after TIMEOUT cycles. Optional feature
// macro MEM_ALIGN_CHECK_EN drops misaligned accesses and pulses misalign_o.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALU_Res_i,
    input  logic [31:0] MemWrite_Data_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] ALU_Res_o,
    output logic [31:0] MemRead_Data_o,
    output logic [4:0]  RDaddr_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic        err_o,
    output logic        misalign_o
);

    // Timeout fires on the edge where the counter would reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rbuf_q;
    logic             aborted_q;
    logic             err_q;
    logic             mem_op;
    logic             misaligned;
    logic             timeout_hit;
    logic             load_fields;
    memwb_t           wb_d, wb_q;

    assign mem_op      = MemRead_i | MemWrite_i;
    assign timeout_hit = (state_q == ST_ACCESS) && !mem_ack_i && (cnt_q == CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;

    assign misaligned = mem_op && (ALU_Res_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q == ST_IDLE) && misaligned;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misaligned = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        stall_o         = 1'b0;
        load_fields     = 1'b0;
        wb_d.alu_res    = ALU_Res_i;
        wb_d.rdata      = 32'h0;
        wb_d.rd         = RDaddr_i;
        wb_d.reg_write  = RegWrite_i;
        wb_d.mem_to_reg = MemtoReg_i;

        case (state_q)
            ST_IDLE: begin
                if (misaligned) begin
                    load_fields    = 1'b1;
                    wb_d.reg_write = 1'b0;
                end else if (mem_op) begin
                    stall_o = 1'b1;
                    state_d = ST_ACCESS;
                end else begin
                    load_fields = 1'b1;
                end
            end
            ST_ACCESS: begin
                stall_o = 1'b1;
                if (mem_ack_i || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                load_fields = 1'b1;
                wb_d.rdata  = rbuf_q;
                if (aborted_q) begin
                    wb_d.reg_write = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rbuf_q      <= 32'h0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (mem_op && !misaligned) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= MemWrite_i;
                        mem_addr_o  <= ALU_Res_i;
                        mem_wdata_o <= MemWrite_Data_i;
                        cnt_q       <= '0;
                        aborted_q   <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Ack wins over a timeout landing on the same edge.
                    if (mem_ack_i) begin
                        rbuf_q    <= mem_we_o ? 32'h0 : mem_rdata_i;
                        mem_req_o <= 1'b0;
                    end else if (timeout_hit) begin
                        rbuf_q    <= 32'h0;
                        mem_req_o <= 1'b0;
                        err_q     <= 1'b1;
                        aborted_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    cnt_q     <= '0;
                    aborted_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    memwb_reg u_memwb_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_fields (load_fields),
        .fields      (wb_d),
        .q           (wb_q)
    );

    assign ALU_Res_o      = wb_q.alu_res;
    assign MemRead_Data_o = wb_q.rdata;
    assign RDaddr_o       = wb_q.rd;
    assign RegWrite_o     = wb_q.reg_write;
    assign MemtoReg_o     = wb_q.mem_to_reg;
    assign err_o          = err_q;

endmodule
